// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: stall-vector layout,
// stall encodings, FSM states and common word constants.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W = 6;

    localparam int unsigned STALL_BIT_PC    = 0;
    localparam int unsigned STALL_BIT_IF_ID = 1;
    localparam int unsigned STALL_BIT_ID_EX = 2;
    localparam int unsigned STALL_BIT_EX_MEM = 3;
    localparam int unsigned STALL_BIT_MEM_WB = 4;
    localparam int unsigned STALL_BIT_WB    = 5;

    // Each encoding freezes the requesting stage and everything upstream of it.
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } pipe_state_e;

    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam int unsigned HOLD_W = 3;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating stall/flush performance counters and the sticky consecutive-stall
// watchdog.
module pipe_perf_cnt #(
    parameter int unsigned MAX_STALL = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall_active,
    input  logic        i_flush,
    output logic [31:0] o_stall_cycles,
    output logic [15:0] o_flush_count,
    output logic        o_stall_timeout
);

    localparam int unsigned CNT_W = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;
    localparam logic [CNT_W-1:0] CONSEC_LIM = CNT_W'(MAX_STALL - 1);

    logic [CNT_W-1:0] r_consec;
    logic [31:0]      r_stall_cycles;
    logic [15:0]      r_flush_count;
    logic             r_stall_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_consec        <= '0;
            r_stall_cycles  <= '0;
            r_flush_count   <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            // The run length parks at the limit; the flag is what matters after that.
            if (i_stall_active && !i_flush) begin
                if (r_consec == CONSEC_LIM) begin
                    r_stall_timeout <= 1'b1;
                end else begin
                    r_consec <= r_consec + 1'b1;
                end
            end else begin
                r_consec <= '0;
            end

            if (i_stall_active && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end

            if (i_flush && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign o_stall_cycles  = r_stall_cycles;
    assign o_flush_count   = r_flush_count;
    assign o_stall_timeout = r_stall_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: prioritises stage stall requests and MEM flushes,
// masks early-stage stalls for a short window after a flush, and tracks perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MAX_STALL  = 1024,
    parameter int unsigned FLUSH_HOLD = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_stallreq_if,
    input  logic               i_stallreq_id,
    input  logic               i_stallreq_ex,
    input  logic               i_stallreq_mem,
    input  logic               i_flush_req,
    input  logic [31:0]        i_flush_pc,
    output logic [STALL_W-1:0] o_stall,
    output logic               o_flush,
    output logic [31:0]        o_new_pc,
    output logic [31:0]        o_stall_cycles,
    output logic [15:0]        o_flush_count,
    output logic               o_stall_timeout
);

    pipe_state_e       r_state;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic               w_mask;
    logic               w_req_if;
    logic               w_req_id;
    logic [STALL_W-1:0] w_stall;
    logic               w_flush;
    logic [31:0]        w_new_pc;
    logic               w_stall_active;

    always_comb begin
        w_mask   = (r_state == StFlush);
        w_req_if = i_stallreq_if & ~w_mask;
        w_req_id = i_stallreq_id & ~w_mask;
        w_stall  = STALL_NONE;
        w_flush  = DISABLE;
        w_new_pc = ZERO_WORD;
        if (rst) begin
            w_stall = STALL_NONE;
        end else if (i_flush_req) begin
            w_flush  = ENABLE;
            w_new_pc = i_flush_pc;
        end else if (i_stallreq_mem) begin
            w_stall = STALL_MEM;
        end else if (i_stallreq_ex) begin
            w_stall = STALL_EX;
        end else if (w_req_id) begin
            w_stall = STALL_ID;
        end else if (w_req_if) begin
            w_stall = STALL_IF;
        end
    end

    assign w_stall_active = |w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StRun;
            r_hold_cnt <= '0;
        end else if (w_flush) begin
            // Every flush cycle restarts the masking window.
            r_hold_cnt <= HOLD_W'(FLUSH_HOLD);
            r_state    <= (FLUSH_HOLD == 0) ? StRun : StFlush;
        end else begin
            unique case (r_state)
                StFlush: begin
                    if (r_hold_cnt > 1) begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end else begin
                        r_hold_cnt <= '0;
                        r_state    <= w_stall_active ? StStall : StRun;
                    end
                end
                default: r_state <= w_stall_active ? StStall : StRun;
            endcase
        end
    end

    pipe_perf_cnt #(
        .MAX_STALL(MAX_STALL)
    ) u_perf (
        .clk            (clk),
        .rst            (rst),
        .i_stall_active (w_stall_active),
        .i_flush        (w_flush),
        .o_stall_cycles (o_stall_cycles),
        .o_flush_count  (o_flush_count),
        .o_stall_timeout(o_stall_timeout)
    );

    assign o_stall  = w_stall;
    assign o_flush  = w_flush;
    assign o_new_pc = w_new_pc;

endmodule
